// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, M-extension
// selectors, operand-B sources and the M-extension funct3 values.
package ex_pkg;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_SLL  = 5'd2,
      ALU_SLT  = 5'd3,
      ALU_SLTU = 5'd4,
      ALU_XOR  = 5'd5,
      ALU_SRL  = 5'd6,
      ALU_SRA  = 5'd7,
      ALU_OR   = 5'd8,
      ALU_AND  = 5'd9,
      ALU_LUI  = 5'd10,
      ALU_ADDW = 5'd11,
      ALU_SUBW = 5'd12,
      ALU_SLLW = 5'd13,
      ALU_SRLW = 5'd14,
      ALU_SRAW = 5'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      MUL_BASE = 2'd0,
      MUL_MEXT = 2'd1
   } mul_op_e;

   typedef enum logic [1:0] {
      SRCB_BUSB = 2'd0,
      SRCB_IMM  = 2'd1,
      SRCB_FOUR = 2'd2,
      SRCB_ZERO = 2'd3
   } srcb_e;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

endpackage

// File: rtl/ex_alu.sv
// Combinational RV64IM ALU: base integer ops, word ops and single-cycle
// multiply/divide with RISC-V divide-by-zero and overflow results.
module ex_alu
   import ex_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [4:0]      ALUOp_i,
   input  logic [1:0]      MulOp_i,
   output logic [XLEN-1:0] ALURes_o
);

   localparam int              ShW  = $clog2(XLEN);
   localparam logic [XLEN-1:0] MinS = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [31:0]     MinW = 32'h8000_0000;

   function automatic logic [XLEN-1:0] sextW(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   logic [31:0]         a32, b32, wRes;
   logic [XLEN-1:0]     baseRes, mextRes;
   logic [2:0]          funct3;
   logic                isW;
   logic                mulASigned, mulBSigned;
   logic [2*XLEN-1:0]   mulA, mulB, prod;
   logic                divZero, divOvf, divZeroW, divOvfW;
   logic [XLEN-1:0]     divisorS, divisorU, quotS, remS, quotU, remU;
   logic [31:0]         divisorSW, divisorUW, quotW, remW, quotUW, remUW;

   assign a32    = a_i[31:0];
   assign b32    = b_i[31:0];
   assign funct3 = ALUOp_i[2:0];
   assign isW    = ALUOp_i[3];

   always_comb begin
      wRes = '0;
      case (ALUOp_i)
         ALU_ADDW: wRes = a32 + b32;
         ALU_SUBW: wRes = a32 - b32;
         ALU_SLLW: wRes = a32 << b32[4:0];
         ALU_SRLW: wRes = a32 >> b32[4:0];
         ALU_SRAW: wRes = $signed(a32) >>> b32[4:0];
         default:  wRes = '0;
      endcase
   end

   always_comb begin
      baseRes = '0;
      case (ALUOp_i)
         ALU_ADD:  baseRes = a_i + b_i;
         ALU_SUB:  baseRes = a_i - b_i;
         ALU_SLL:  baseRes = a_i << b_i[ShW-1:0];
         ALU_SLT:  baseRes = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: baseRes = {{(XLEN-1){1'b0}}, a_i < b_i};
         ALU_XOR:  baseRes = a_i ^ b_i;
         ALU_SRL:  baseRes = a_i >> b_i[ShW-1:0];
         ALU_SRA:  baseRes = $signed(a_i) >>> b_i[ShW-1:0];
         ALU_OR:   baseRes = a_i | b_i;
         ALU_AND:  baseRes = a_i & b_i;
         ALU_LUI:  baseRes = b_i;
         ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW: baseRes = sextW(wRes);
         default:  baseRes = '0;
      endcase
   end

   // One double-width multiplier; the extension of each operand picks the high-half flavour.
   assign mulASigned = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
   assign mulBSigned = (funct3 == F3_MULH);
   assign mulA       = {{XLEN{mulASigned & a_i[XLEN-1]}}, a_i};
   assign mulB       = {{XLEN{mulBSigned & b_i[XLEN-1]}}, b_i};
   assign prod       = mulA * mulB;

   // Dividing MIN by 1 instead of -1 yields the architected quotient MIN and remainder 0.
   assign divZero  = (b_i == '0);
   assign divOvf   = (a_i == MinS) && (b_i == '1);
   assign divisorS = (divZero || divOvf) ? XLEN'(1) : b_i;
   assign divisorU = divZero ? XLEN'(1) : b_i;
   assign quotS    = $signed(a_i) / $signed(divisorS);
   assign remS     = $signed(a_i) % $signed(divisorS);
   assign quotU    = a_i / divisorU;
   assign remU     = a_i % divisorU;

   assign divZeroW  = (b32 == '0);
   assign divOvfW   = (a32 == MinW) && (b32 == '1);
   assign divisorSW = (divZeroW || divOvfW) ? 32'd1 : b32;
   assign divisorUW = divZeroW ? 32'd1 : b32;
   assign quotW     = $signed(a32) / $signed(divisorSW);
   assign remW      = $signed(a32) % $signed(divisorSW);
   assign quotUW    = a32 / divisorUW;
   assign remUW     = a32 % divisorUW;

   always_comb begin
      mextRes = '0;
      if (!isW) begin
         case (funct3)
            F3_MUL:                       mextRes = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: mextRes = prod[2*XLEN-1:XLEN];
            F3_DIV:                       mextRes = divZero ? '1 : quotS;
            F3_DIVU:                      mextRes = divZero ? '1 : quotU;
            F3_REM:                       mextRes = divZero ? a_i : remS;
            F3_REMU:                      mextRes = divZero ? a_i : remU;
            default:                      mextRes = '0;
         endcase
      end else begin
         case (funct3)
            F3_MUL:  mextRes = sextW(prod[31:0]);
            F3_DIV:  mextRes = sextW(divZeroW ? 32'hFFFF_FFFF : quotW);
            F3_DIVU: mextRes = sextW(divZeroW ? 32'hFFFF_FFFF : quotUW);
            F3_REM:  mextRes = sextW(divZeroW ? a32 : remW);
            F3_REMU: mextRes = sextW(divZeroW ? a32 : remUW);
            default: mextRes = '0;
         endcase
      end
   end

   always_comb begin
      ALURes_o = '0;
      case (MulOp_i)
         MUL_BASE: ALURes_o = baseRes;
         MUL_MEXT: ALURes_o = mextRes;
         default:  ALURes_o = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register feeding the combinational ALU.
// Registered fields pass straight through to the EX/M register.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            enable,
   input  logic            valid_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   input  logic [4:0]      rd_i,
   input  logic [XLEN-1:0] busa_i,
   input  logic [XLEN-1:0] busb_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] Csrres_i,
   input  logic            ALUSrcA_i,
   input  logic [1:0]      ALUSrcB_i,
   input  logic [4:0]      ALUOp_i,
   input  logic [1:0]      MulOp_i,
   input  logic [2:0]      MemOp_i,
   input  logic            MemToReg_i,
   input  logic            MemWen_i,
   input  logic            wen_i,
   input  logic            CsrToReg_i,
   input  logic            Ebreak_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [31:0]     instr_o,
   output logic [4:0]      rd_o,
   output logic [XLEN-1:0] busa_o,
   output logic [XLEN-1:0] busb_o,
   output logic [XLEN-1:0] imm_o,
   output logic [XLEN-1:0] Csrres_o,
   output logic            ALUSrcA_o,
   output logic [1:0]      ALUSrcB_o,
   output logic [4:0]      ALUOp_o,
   output logic [1:0]      MulOp_o,
   output logic [2:0]      MemOp_o,
   output logic            MemToReg_o,
   output logic            MemWen_o,
   output logic            wen_o,
   output logic            CsrToReg_o,
   output logic            Ebreak_o,
   output logic [XLEN-1:0] ALURes
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] busa_q, busa_d, busb_q, busb_d, imm_q, imm_d, Csrres_q, Csrres_d;
   logic            ALUSrcA_q, ALUSrcA_d;
   logic [1:0]      ALUSrcB_q, ALUSrcB_d;
   logic [4:0]      ALUOp_q, ALUOp_d;
   logic [1:0]      MulOp_q, MulOp_d;
   logic [2:0]      MemOp_q, MemOp_d;
   logic            MemToReg_q, MemToReg_d, MemWen_q, MemWen_d, wen_q, wen_d;
   logic            CsrToReg_q, CsrToReg_d, Ebreak_q, Ebreak_d;
   logic [XLEN-1:0] opA, opB;

   // A flush only kills the side-effecting flags; data fields simply hold.
   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      rd_d       = rd_q;
      busa_d     = busa_q;
      busb_d     = busb_q;
      imm_d      = imm_q;
      Csrres_d   = Csrres_q;
      ALUSrcA_d  = ALUSrcA_q;
      ALUSrcB_d  = ALUSrcB_q;
      ALUOp_d    = ALUOp_q;
      MulOp_d    = MulOp_q;
      MemOp_d    = MemOp_q;
      MemToReg_d = MemToReg_q;
      MemWen_d   = MemWen_q;
      wen_d      = wen_q;
      CsrToReg_d = CsrToReg_q;
      Ebreak_d   = Ebreak_q;
      if (flush) begin
         valid_d    = 1'b0;
         MemToReg_d = 1'b0;
         MemWen_d   = 1'b0;
         wen_d      = 1'b0;
         CsrToReg_d = 1'b0;
         Ebreak_d   = 1'b0;
      end else if (enable) begin
         valid_d    = valid_i;
         pc_d       = pc_i;
         instr_d    = instr_i;
         rd_d       = rd_i;
         busa_d     = busa_i;
         busb_d     = busb_i;
         imm_d      = imm_i;
         Csrres_d   = Csrres_i;
         ALUSrcA_d  = ALUSrcA_i;
         ALUSrcB_d  = ALUSrcB_i;
         ALUOp_d    = ALUOp_i;
         MulOp_d    = MulOp_i;
         MemOp_d    = MemOp_i;
         MemToReg_d = MemToReg_i;
         MemWen_d   = MemWen_i;
         wen_d      = wen_i;
         CsrToReg_d = CsrToReg_i;
         Ebreak_d   = Ebreak_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         instr_q    <= '0;
         rd_q       <= '0;
         busa_q     <= '0;
         busb_q     <= '0;
         imm_q      <= '0;
         Csrres_q   <= '0;
         ALUSrcA_q  <= 1'b0;
         ALUSrcB_q  <= '0;
         ALUOp_q    <= '0;
         MulOp_q    <= '0;
         MemOp_q    <= '0;
         MemToReg_q <= 1'b0;
         MemWen_q   <= 1'b0;
         wen_q      <= 1'b0;
         CsrToReg_q <= 1'b0;
         Ebreak_q   <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         rd_q       <= rd_d;
         busa_q     <= busa_d;
         busb_q     <= busb_d;
         imm_q      <= imm_d;
         Csrres_q   <= Csrres_d;
         ALUSrcA_q  <= ALUSrcA_d;
         ALUSrcB_q  <= ALUSrcB_d;
         ALUOp_q    <= ALUOp_d;
         MulOp_q    <= MulOp_d;
         MemOp_q    <= MemOp_d;
         MemToReg_q <= MemToReg_d;
         MemWen_q   <= MemWen_d;
         wen_q      <= wen_d;
         CsrToReg_q <= CsrToReg_d;
         Ebreak_q   <= Ebreak_d;
      end
   end

   assign valid_o    = valid_q;
   assign pc_o       = pc_q;
   assign instr_o    = instr_q;
   assign rd_o       = rd_q;
   assign busa_o     = busa_q;
   assign busb_o     = busb_q;
   assign imm_o      = imm_q;
   assign Csrres_o   = Csrres_q;
   assign ALUSrcA_o  = ALUSrcA_q;
   assign ALUSrcB_o  = ALUSrcB_q;
   assign ALUOp_o    = ALUOp_q;
   assign MulOp_o    = MulOp_q;
   assign MemOp_o    = MemOp_q;
   assign MemToReg_o = MemToReg_q;
   assign MemWen_o   = MemWen_q;
   assign wen_o      = wen_q;
   assign CsrToReg_o = CsrToReg_q;
   assign Ebreak_o   = Ebreak_q;

   assign opA = ALUSrcA_q ? pc_q : busa_q;

   always_comb begin
      opB = '0;
      case (ALUSrcB_q)
         SRCB_BUSB: opB = busb_q;
         SRCB_IMM:  opB = imm_q;
         SRCB_FOUR: opB = XLEN'(4);
         default:   opB = '0;
      endcase
   end

   ex_alu #(
      .XLEN(XLEN)
   ) u_alu (
      .a_i     (opA),
      .b_i     (opB),
      .ALUOp_i (ALUOp_q),
      .MulOp_i (MulOp_q),
      .ALURes_o(ALURes)
   );

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed corner cases then randomized traffic, checked
// against an arithmetic model of the register stage and RV64IM ALU.
module tb_ex_stage;

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [63:0] busa;
      logic [63:0] busb;
      logic [63:0] imm;
      logic [63:0] csr;
      logic        srcA;
      logic [1:0]  srcB;
      logic [4:0]  aluOp;
      logic [1:0]  mulOp;
      logic [2:0]  memOp;
      logic        memToReg;
      logic        memWen;
      logic        wen;
      logic        csrToReg;
      logic        ebreak;
   } stage_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   logic   flush = 1'b0;
   logic   enable = 1'b0;
   stage_t drv = '0;
   stage_t model = '0;
   logic   dataKnown = 1'b1;
   int     compared = 0;
   int     mismatched = 0;

   logic        valid_o, ALUSrcA_o, MemToReg_o, MemWen_o, wen_o, CsrToReg_o, Ebreak_o;
   logic [63:0] pc_o, busa_o, busb_o, imm_o, Csrres_o, ALURes;
   logic [31:0] instr_o;
   logic [4:0]  rd_o, ALUOp_o;
   logic [1:0]  ALUSrcB_o, MulOp_o;
   logic [2:0]  MemOp_o;

   ex_stage #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .flush(flush), .enable(enable),
      .valid_i(drv.valid), .pc_i(drv.pc), .instr_i(drv.instr), .rd_i(drv.rd),
      .busa_i(drv.busa), .busb_i(drv.busb), .imm_i(drv.imm), .Csrres_i(drv.csr),
      .ALUSrcA_i(drv.srcA), .ALUSrcB_i(drv.srcB), .ALUOp_i(drv.aluOp),
      .MulOp_i(drv.mulOp), .MemOp_i(drv.memOp), .MemToReg_i(drv.memToReg),
      .MemWen_i(drv.memWen), .wen_i(drv.wen), .CsrToReg_i(drv.csrToReg),
      .Ebreak_i(drv.ebreak),
      .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o), .rd_o(rd_o),
      .busa_o(busa_o), .busb_o(busb_o), .imm_o(imm_o), .Csrres_o(Csrres_o),
      .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
      .MulOp_o(MulOp_o), .MemOp_o(MemOp_o), .MemToReg_o(MemToReg_o),
      .MemWen_o(MemWen_o), .wen_o(wen_o), .CsrToReg_o(CsrToReg_o),
      .Ebreak_o(Ebreak_o), .ALURes(ALURes)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Reference ALU from the instruction-set rules; mulh/mulhsu use the
   // unsigned high product minus the usual sign corrections.
   function automatic logic [63:0] refAlu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [4:0] op, input logic [1:0] mop);
      longint      sa, sb;
      int          sa32, sb32;
      logic [31:0] a32, b32;
      logic [127:0] ea, eb, pu;
      logic [63:0] hu;
      sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      ea = {64'd0, a}; eb = {64'd0, b}; pu = ea * eb; hu = pu[127:64];
      if (mop == 2'd0) begin
         case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[5:0];
            5'd3:  return (sa < sb) ? 64'd1 : 64'd0;
            5'd4:  return (a < b) ? 64'd1 : 64'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[5:0];
            5'd7:  return sa >>> b[5:0];
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd11: return sx(a32 + b32);
            5'd12: return sx(a32 - b32);
            5'd13: return sx(a32 << b[4:0]);
            5'd14: return sx(a32 >> b[4:0]);
            5'd15: return sx(sa32 >>> b[4:0]);
            default: return 64'd0;
         endcase
      end
      if (mop != 2'd1) return 64'd0;
      if (!op[3]) begin
         case (op[2:0])
            3'd0: return a * b;
            3'd1: return hu - (a[63] ? b : 64'd0) - (b[63] ? a : 64'd0);
            3'd2: return hu - (a[63] ? b : 64'd0);
            3'd3: return hu;
            3'd4: begin
               if (b == 0) return ONES;
               if (a == MIN64 && b == ONES) return MIN64;
               return sa / sb;
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
               if (b == 0) return a;
               if (a == MIN64 && b == ONES) return 64'd0;
               return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
         endcase
      end
      case (op[2:0])
         3'd0: return sx(a32 * b32);
         3'd4: begin
            if (b32 == 0) return ONES;
            if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx(a32);
            return sx(sa32 / sb32);
         end
         3'd5: return (b32 == 0) ? ONES : sx(a32 / b32);
         3'd6: begin
            if (b32 == 0) return sx(a32);
            if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
            return sx(sa32 % sb32);
         end
         3'd7: return (b32 == 0) ? sx(a32) : sx(a32 % b32);
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'd1;
         2: return ONES;
         3: return MIN64;
         4: return 64'hFFFF_FFFF_8000_0000;
         5: return 64'h0000_0000_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic stage_t randStage();
      stage_t s;
      s.valid    = 1'($urandom);
      s.pc       = {$urandom, $urandom};
      s.instr    = $urandom;
      s.rd       = 5'($urandom);
      s.busa     = pickOperand();
      s.busb     = pickOperand();
      s.imm      = pickOperand();
      s.csr      = {$urandom, $urandom};
      s.srcA     = 1'($urandom);
      s.srcB     = 2'($urandom);
      s.aluOp    = 5'($urandom);
      s.mulOp    = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'($urandom_range(0, 1));
      s.memOp    = 3'($urandom);
      s.memToReg = 1'($urandom);
      s.memWen   = 1'($urandom);
      s.wen      = 1'($urandom);
      s.csrToReg = 1'($urandom);
      s.ebreak   = 1'($urandom);
      return s;
   endfunction

   function automatic stage_t mkOp(input logic [63:0] pc, input logic [63:0] busa,
                                   input logic [63:0] busb, input logic [63:0] imm,
                                   input logic srcA, input logic [1:0] srcB,
                                   input logic [4:0] aluOp, input logic [1:0] mulOp);
      stage_t s;
      s = randStage();
      s.valid = 1'b1; s.pc = pc; s.busa = busa; s.busb = busb; s.imm = imm;
      s.srcA = srcA; s.srcB = srcB; s.aluOp = aluOp; s.mulOp = mulOp;
      s.wen = 1'b1; s.ebreak = 1'b1;
      return s;
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic clockStep();
      stage_t snap;
      logic   fl, en;
      snap = drv; fl = flush; en = enable;
      @(posedge clk);
      #1;
      if (fl) begin
         model.valid = 1'b0; model.memToReg = 1'b0; model.memWen = 1'b0;
         model.wen = 1'b0; model.csrToReg = 1'b0; model.ebreak = 1'b0;
         dataKnown = 1'b0;
      end else if (en) begin
         model = snap;
         dataKnown = 1'b1;
      end
   endtask

   task automatic applyStimulus(input stage_t s, input logic en, input logic fl);
      drv = s; enable = en; flush = fl;
      clockStep();
   endtask

   task automatic checkOutput(input string tag);
      logic [63:0] opA, opB;
      checkVal({tag, ":flags"},
               64'({valid_o, MemToReg_o, MemWen_o, wen_o, CsrToReg_o, Ebreak_o}),
               64'({model.valid, model.memToReg, model.memWen, model.wen, model.csrToReg, model.ebreak}));
      if (dataKnown) begin
         checkVal({tag, ":pc"}, pc_o, model.pc);
         checkVal({tag, ":instr_rd"}, 64'({instr_o, rd_o}), 64'({model.instr, model.rd}));
         checkVal({tag, ":busa"}, busa_o, model.busa);
         checkVal({tag, ":busb"}, busb_o, model.busb);
         checkVal({tag, ":imm"}, imm_o, model.imm);
         checkVal({tag, ":csr"}, Csrres_o, model.csr);
         checkVal({tag, ":ctrl"}, 64'({ALUSrcA_o, ALUSrcB_o, ALUOp_o, MulOp_o, MemOp_o}),
                  64'({model.srcA, model.srcB, model.aluOp, model.mulOp, model.memOp}));
         opA = model.srcA ? model.pc : model.busa;
         case (model.srcB)
            2'd0:    opB = model.busb;
            2'd1:    opB = model.imm;
            2'd2:    opB = 64'd4;
            default: opB = 64'd0;
         endcase
         checkVal({tag, ":alures"}, ALURes, refAlu(opA, opB, model.aluOp, model.mulOp));
      end
   endtask

   task automatic runOp(input string tag, input stage_t s, input logic [63:0] expected);
      applyStimulus(s, 1'b1, 1'b0);
      checkOutput(tag);
      checkVal({tag, ":const"}, ALURes, expected);
   endtask

   initial begin
      $display("[TB] ex_stage bench start");
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      rst = 1'b0;
      applyStimulus(randStage(), 1'b0, 1'b0);
      checkOutput("release_hold");
      checkVal("release_alures", ALURes, 64'd0);

      runOp("addi", mkOp(64'd0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 2'd1, 5'd0, 2'd0), 64'd2);
      checkVal("addi_valid", 64'(valid_o), 64'd1);
      applyStimulus(randStage(), 1'b0, 1'b0);
      checkOutput("hold");
      checkVal("hold_alures", ALURes, 64'd2);
      applyStimulus(mkOp(64'd1, 64'd2, 64'd3, 64'd4, 1'b0, 2'd0, 5'd0, 2'd0), 1'b1, 1'b1);
      checkOutput("flush");
      checkVal("flush_vwe", 64'({valid_o, wen_o, Ebreak_o}), 64'd0);

      runOp("auipc", mkOp(64'h8000_0000, 64'd0, 64'd0, 64'd0, 1'b1, 2'd2, 5'd0, 2'd0), 64'h8000_0004);
      runOp("addw", mkOp(64'd0, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0, 2'd0, 5'd11, 2'd0), 64'hFFFF_FFFF_8000_0000);
      runOp("sraw", mkOp(64'd0, 64'h8000_0000, 64'd4, 64'd0, 1'b0, 2'd0, 5'd15, 2'd0), 64'hFFFF_FFFF_F800_0000);
      runOp("slt", mkOp(64'd0, ONES, 64'd1, 64'd0, 1'b0, 2'd0, 5'd3, 2'd0), 64'd1);
      runOp("sltu", mkOp(64'd0, ONES, 64'd1, 64'd0, 1'b0, 2'd0, 5'd4, 2'd0), 64'd0);
      runOp("lui", mkOp(64'd0, 64'd7, 64'd0, 64'h1234_5000, 1'b0, 2'd1, 5'd10, 2'd0), 64'h1234_5000);
      runOp("srcb_zero", mkOp(64'd0, 64'd9, 64'd5, 64'd5, 1'b0, 2'd3, 5'd0, 2'd0), 64'd9);
      runOp("div_by0", mkOp(64'd0, 64'd7, 64'd0, 64'd0, 1'b0, 2'd0, 5'd4, 2'd1), ONES);
      runOp("rem_by0", mkOp(64'd0, 64'd7, 64'd0, 64'd0, 1'b0, 2'd0, 5'd6, 2'd1), 64'd7);
      runOp("div_ovf", mkOp(64'd0, MIN64, ONES, 64'd0, 1'b0, 2'd0, 5'd4, 2'd1), MIN64);
      runOp("rem_ovf", mkOp(64'd0, MIN64, ONES, 64'd0, 1'b0, 2'd0, 5'd6, 2'd1), 64'd0);
      runOp("mulhu", mkOp(64'd0, ONES, ONES, 64'd0, 1'b0, 2'd0, 5'd3, 2'd1), 64'hFFFF_FFFF_FFFF_FFFE);
      runOp("mulh", mkOp(64'd0, ONES, ONES, 64'd0, 1'b0, 2'd0, 5'd1, 2'd1), 64'd0);
      runOp("divw_by0", mkOp(64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 2'd0, 5'd12, 2'd1), ONES);
      runOp("divw_ovf", mkOp(64'd0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b0, 2'd0, 5'd12, 2'd1), 64'hFFFF_FFFF_8000_0000);
      runOp("remuw_by0", mkOp(64'd0, 64'h1_8000_0000, 64'd0, 64'd0, 1'b0, 2'd0, 5'd15, 2'd1), 64'hFFFF_FFFF_8000_0000);
      runOp("mulhw_inv", mkOp(64'd0, ONES, ONES, 64'd0, 1'b0, 2'd0, 5'd9, 2'd1), 64'd0);
      runOp("mulop_rsv", mkOp(64'd0, 64'd1, 64'd1, 64'd0, 1'b0, 2'd0, 5'd0, 2'd2), 64'd0);
      runOp("aluop_hi", mkOp(64'd0, 64'd1, 64'd1, 64'd0, 1'b0, 2'd0, 5'd20, 2'd0), 64'd0);

      for (int i = 0; i < 600; i++) begin
         applyStimulus(randStage(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
         checkOutput($sformatf("rand%0d", i));
      end

      applyStimulus(mkOp(64'd0, 64'd3, 64'd4, 64'd0, 1'b0, 2'd0, 5'd0, 2'd0), 1'b1, 1'b0);
      checkVal("pre_areset", ALURes, 64'd7);
      #2 rst = 1'b1;
      #1;
      model = '0;
      dataKnown = 1'b1;
      checkOutput("async_reset");
      checkVal("async_reset_alures", ALURes, 64'd0);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
